// File: rtl/panel_switch_input.sv
// Front-panel switch input for the Altair 8800 core.
// Five push-buttons are synchronized and debounced, and their press events
// steer a cursor over the 16 toggle switches (row 0) and the 8 momentary
// control switches (row 1). Select toggles an address switch or issues a
// control command to the sequencer over a valid/ready handshake.

// Per-button synchronizer + debouncer + rising-edge press detector.
module panel_switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             deb;
  logic             deb_q;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer; sync[1] is the metastability-safe sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[0], raw};
  end

  // Count consecutive samples that disagree with the accepted level; flip
  // the accepted level once DEBOUNCE_CYCLES disagreeing samples are seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync[1] == deb) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
      deb <= ~deb;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Previous accepted level, for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) deb_q <= 1'b0;
    else        deb_q <= deb;
  end

  // One-cycle pulse on press only; releases are silent.
  assign press = deb & ~deb_q;
endmodule

// Top level: cursor, toggle switches and control command handshake.
module panel_switch_input #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  output logic [15:0] addr_sw,
  output logic        cursor_row,
  output logic [3:0]  cursor_col,
  output logic        ctrl_valid,
  output logic [2:0]  ctrl_code,
  input  logic        ctrl_ready
);
  localparam int NUM_BTN = 5;
  localparam int B_SEL   = 0;
  localparam int B_RIGHT = 1;
  localparam int B_LEFT  = 2;
  localparam int B_DOWN  = 3;
  localparam int B_UP    = 4;

  typedef enum logic [2:0] {
    EV_NONE, EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT, EV_SEL
  } ev_e;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;
  ev_e                ev;
  logic [3:0]         col_inc;
  logic [3:0]         col_dec;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right, btn_select};

  // One debouncer per button.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    panel_switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[i]),
      .press (press[i])
    );
  end

  // Pick a single event per cycle; lower-priority coincident presses are lost.
  always_comb begin
    ev = EV_NONE;
    if      (press[B_UP])    ev = EV_UP;
    else if (press[B_DOWN])  ev = EV_DOWN;
    else if (press[B_LEFT])  ev = EV_LEFT;
    else if (press[B_RIGHT]) ev = EV_RIGHT;
    else if (press[B_SEL])   ev = EV_SEL;
  end

  // Column step with row-dependent wrap: mod 16 on toggles, mod 8 on controls.
  always_comb begin
    col_inc = cursor_col + 4'd1;
    col_dec = cursor_col - 4'd1;
    if (cursor_row) begin
      col_inc = {1'b0, cursor_col[2:0] + 3'd1};
      col_dec = {1'b0, cursor_col[2:0] - 3'd1};
    end
  end

  // Cursor movement; entering the 8-wide control row clamps the column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cursor_row <= 1'b0;
      cursor_col <= 4'd0;
    end else begin
      case (ev)
        EV_UP, EV_DOWN: begin
          cursor_row <= ~cursor_row;
          if (!cursor_row && cursor_col > 4'd7) cursor_col <= 4'd7;
        end
        EV_LEFT:  cursor_col <= col_inc;
        EV_RIGHT: cursor_col <= col_dec;
        default: ;
      endcase
    end
  end

  // Select on the toggle row flips the switch under the cursor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          addr_sw <= 16'h0000;
    else if (ev == EV_SEL && !cursor_row) addr_sw <= addr_sw ^ (16'h0001 << cursor_col);
  end

  // Control command: a pending command blocks new selects until accepted;
  // ctrl_code only loads while idle so it holds steady under valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_valid <= 1'b0;
      ctrl_code  <= 3'd0;
    end else if (ctrl_valid) begin
      if (ctrl_ready) ctrl_valid <= 1'b0;
    end else if (ev == EV_SEL && cursor_row) begin
      ctrl_valid <= 1'b1;
      ctrl_code  <= cursor_col[2:0];
    end
  end
endmodule

// File: tb/tb_panel_switch_input.sv
// Directed bench for panel_switch_input with DEBOUNCE_CYCLES=4.
module tb_panel_switch_input;
  localparam int DB = 4;
  localparam int OP_U = 0, OP_D = 1, OP_L = 2, OP_R = 3, OP_S = 4, OP_RST = 5, OP_RDY = 6;

  typedef struct {
    int          op;
    int          hold;
    logic        row;
    logic [3:0]  col;
    logic [15:0] addr;
    logic        valid;
    logic [2:0]  code;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  raw = '0;
  logic        ctrl_ready = 1'b0;
  logic [15:0] addr_sw;
  logic        cursor_row;
  logic [3:0]  cursor_col;
  logic        ctrl_valid;
  logic [2:0]  ctrl_code;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  panel_switch_input #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (raw[OP_U]),
    .btn_down   (raw[OP_D]),
    .btn_left   (raw[OP_L]),
    .btn_right  (raw[OP_R]),
    .btn_select (raw[OP_S]),
    .addr_sw    (addr_sw),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .ctrl_valid (ctrl_valid),
    .ctrl_code  (ctrl_code),
    .ctrl_ready (ctrl_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic row, input logic [3:0] col,
                         input logic [15:0] addr, input logic valid, input logic [2:0] code,
                         input bit with_code);
    chk({name, "_row"},   32'(cursor_row), 32'(row));
    chk({name, "_col"},   32'(cursor_col), 32'(col));
    chk({name, "_addr"},  32'(addr_sw),    32'(addr));
    chk({name, "_valid"}, 32'(ctrl_valid), 32'(valid));
    if (with_code) chk({name, "_code"}, 32'(ctrl_code), 32'(code));
  endtask

  task automatic press(input int b, input int hold);
    @(negedge clk);
    raw[b] = 1'b1;
    repeat (hold) @(negedge clk);
    raw[b] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic ready_pulse();
    @(negedge clk);
    ctrl_ready = 1'b1;
    @(negedge clk);
    ctrl_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pat;
    pat = 16'hA5A5;

    // op, hold, row, col, addr, valid, code
    tbl.push_back('{OP_L,   20, 1'b0, 4'd2,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_L,   20, 1'b0, 4'd3,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_L,   10, 1'b0, 4'd4,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_L,   10, 1'b0, 4'd5,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_S,    3, 1'b0, 4'd5,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_S,   10, 1'b0, 4'd5,  16'h0020, 1'b0, 3'd0});
    tbl.push_back('{OP_S,   10, 1'b0, 4'd5,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_RST,  0, 1'b0, 4'd0,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_R,   10, 1'b0, 4'd15, 16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_D,   10, 1'b1, 4'd7,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_L,   10, 1'b1, 4'd0,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_U,   10, 1'b0, 4'd0,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_D,   10, 1'b1, 4'd0,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_L,   10, 1'b1, 4'd1,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_L,   10, 1'b1, 4'd2,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_L,   10, 1'b1, 4'd3,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_S,   10, 1'b1, 4'd3,  16'h0000, 1'b1, 3'd3});
    tbl.push_back('{OP_L,   10, 1'b1, 4'd4,  16'h0000, 1'b1, 3'd3});
    tbl.push_back('{OP_L,   10, 1'b1, 4'd5,  16'h0000, 1'b1, 3'd3});
    tbl.push_back('{OP_S,   10, 1'b1, 4'd5,  16'h0000, 1'b1, 3'd3});
    tbl.push_back('{OP_RDY,  0, 1'b1, 4'd5,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_S,   10, 1'b1, 4'd5,  16'h0000, 1'b1, 3'd5});
    tbl.push_back('{OP_U,   10, 1'b0, 4'd5,  16'h0000, 1'b1, 3'd5});
    tbl.push_back('{OP_S,   10, 1'b0, 4'd5,  16'h0020, 1'b1, 3'd5});
    tbl.push_back('{OP_RDY,  0, 1'b0, 4'd5,  16'h0020, 1'b0, 3'd0});
    tbl.push_back('{OP_RDY,  0, 1'b0, 4'd5,  16'h0020, 1'b0, 3'd0});
    tbl.push_back('{OP_S,   10, 1'b0, 4'd5,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_RST,  0, 1'b0, 4'd0,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_R,   10, 1'b0, 4'd15, 16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_L,   10, 1'b0, 4'd0,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_D,   10, 1'b1, 4'd0,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_R,   10, 1'b1, 4'd7,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_U,   10, 1'b0, 4'd7,  16'h0000, 1'b0, 3'd0});
    tbl.push_back('{OP_D,   10, 1'b1, 4'd7,  16'h0000, 1'b0, 3'd0});

    // Reset state, before any clock edge matters.
    #1;
    chk_all("reset", 1'b0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // First left press: exact landing edge.
    @(negedge clk);
    raw[OP_L] = 1'b1;
    repeat (6) @(negedge clk);
    chk("lat_before", 32'(cursor_col), 32'd0);
    @(negedge clk);
    chk("lat_at", 32'(cursor_col), 32'd1);
    repeat (13) @(negedge clk);
    raw[OP_L] = 1'b0;
    repeat (12) @(negedge clk);

    // Table-driven sequence.
    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_RST:  do_reset();
        OP_RDY:  ready_pulse();
        default: press(tbl[i].op, tbl[i].hold);
      endcase
      chk_all($sformatf("v%0d", i), tbl[i].row, tbl[i].col, tbl[i].addr,
              tbl[i].valid, tbl[i].code, tbl[i].valid || tbl[i].op == OP_RST);
    end

    // Ready already high: valid lasts exactly one cycle. Cursor at (1,7).
    @(negedge clk);
    ctrl_ready = 1'b1;
    raw[OP_S] = 1'b1;
    repeat (6) @(negedge clk);
    chk("minw_before", 32'(ctrl_valid), 32'd0);
    @(negedge clk);
    chk("minw_valid", 32'(ctrl_valid), 32'd1);
    chk("minw_code", 32'(ctrl_code), 32'd7);
    @(negedge clk);
    chk("minw_clear", 32'(ctrl_valid), 32'd0);
    raw[OP_S] = 1'b0;
    ctrl_ready = 1'b0;
    repeat (12) @(negedge clk);

    // Up and select coincide: only up is handled.
    do_reset();
    @(negedge clk);
    raw[OP_U] = 1'b1;
    raw[OP_S] = 1'b1;
    repeat (10) @(negedge clk);
    raw[OP_U] = 1'b0;
    raw[OP_S] = 1'b0;
    repeat (12) @(negedge clk);
    chk_all("coinc", 1'b1, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b0);

    // Build addr_sw=A5A5, cursor (1,6), command pending; then async reset.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (pat[i]) press(OP_S, 10);
      press(OP_L, 10);
    end
    press(OP_D, 10);
    press(OP_R, 10);
    press(OP_R, 10);
    press(OP_S, 10);
    chk_all("pre_rst", 1'b1, 4'd6, 16'hA5A5, 1'b1, 3'd6, 1'b1);
    @(negedge clk);
    raw[OP_D] = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_before", 32'(cursor_row), 32'd0);
    @(negedge clk);
    chk("post_rst_at", 32'(cursor_row), 32'd1);
    raw[OP_D] = 1'b0;
    repeat (12) @(negedge clk);
    chk_all("post_rst_end", 1'b1, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/panel_switch_input.md
# panel_switch_input

Front-panel switch input block for the Altair 8800 core. It debounces the ULX3S push-buttons and drives a cursor over the 16 address/data toggle switches and the 8 momentary control switches. It holds the toggle switch state, issues control-switch commands to the machine sequencer over a valid/ready handshake, and exports the cursor position so the panel renderer can highlight the selected switch.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 250000: number of consecutive stable synchronized samples required before a button change is accepted (10 ms at 25 MHz). Minimum 2.

Ports:
- clk  in  1  pixel/system clock; all state on its rising edge
- reset  in  1  asynchronous, active-low reset
- btn_up, btn_down, btn_left, btn_right, btn_select  in  1 each  raw, asynchronous, active-high buttons
- addr_sw  out  16  toggle switch state (A15..A0; bits 7:0 double as data switches)
- cursor_row  out  1  0 = toggle row, 1 = control row
- cursor_col  out  4  switch index in the current row; bit 0 is the rightmost switch
- ctrl_valid  out  1  control command pending
- ctrl_code  out  3  0 STOP, 1 RUN, 2 SINGLE_STEP, 3 EXAMINE, 4 EXAMINE_NEXT, 5 DEPOSIT, 6 DEPOSIT_NEXT, 7 RESET
- ctrl_ready  in  1  sequencer accepts the command

## Operation
- Each button passes through a 2-flop synchronizer and then its own debouncer:
  - The counter clears whenever the synchronized value equals the debounced value.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the values still differ, the debounced value flips and the counter clears.
- A rising edge of a debounced value (debounced=1, previous debounced=0) produces a one-cycle press event. Releases produce no event. There is no auto-repeat.
- When press events coincide in one cycle, only one is handled, in priority order up > down > left > right > select. Lower-priority events in that cycle are discarded.
- Up and down both toggle cursor_row.
  - Entering row 1 with cursor_col > 7 clamps cursor_col to 7.
  - Entering row 0 keeps cursor_col.
- Left means higher index: cursor_col+1. Right means cursor_col-1.
  - Row 0 wraps modulo 16: 15 followed by left gives 0; 0 followed by right gives 15.
  - Row 1 wraps modulo 8: 7 followed by left gives 0; 0 followed by right gives 7.
- Select on row 0 toggles addr_sw[cursor_col]. This is independent of ctrl_valid.
- Select on row 1:
  - If ctrl_valid=0: set ctrl_valid=1 and ctrl_code=cursor_col[2:0].
  - If ctrl_valid=1: the select is dropped, including in the cycle in which the handshake completes.
- Handshake:
  - ctrl_code is stable while ctrl_valid=1.
  - ctrl_valid clears on the edge where ctrl_valid && ctrl_ready.
  - ctrl_ready while ctrl_valid=0 has no effect.
- Reset state, all asynchronous:
  - addr_sw=0, cursor_row=0, cursor_col=0, ctrl_valid=0, ctrl_code=0.
  - Synchronizers, debounced values, previous values and counters all 0.
  - Reset asserted mid-debounce or mid-handshake discards the in-progress count and the pending command.

## Timing
- All outputs are registered.
- A raw button held high from edge t:
  - synchronized high at t+2
  - debounced high at t+2+DEBOUNCE_CYCLES-1
  - action visible on the outputs one cycle later, at t+2+DEBOUNCE_CYCLES
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- A release must also debounce before the next press can register.
- Handshake: ctrl_valid rises one cycle after the select event and falls one cycle after the first edge with ctrl_ready=1. Minimum valid width is 1 cycle, when ready is already high.
- Counter width is $clog2(DEBOUNCE_CYCLES). Counters never overflow because they clear at the terminal count.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES=4.
- Reset, then btn_left held 20 cycles then released, repeated 3 times -> cursor_col=3, cursor_row=0, addr_sw=0. Each step lands exactly 2+4 cycles after the raw edge.
- A 3-cycle high pulse on btn_select at cursor (0,5) -> no change. Then a 10-cycle press -> addr_sw=16'h0020. A second press -> 16'h0000.
- From reset, btn_right once -> cursor_col=15. Then btn_down -> row=1, col=7. Then btn_left -> col=0. Then btn_up -> row=0, col=0.
- Row 1, col 3, ctrl_ready=0, select -> ctrl_valid=1, ctrl_code=3. Then move to col 5 and select again -> code stays 3. Then ctrl_ready=1 for one cycle -> ctrl_valid=0 on the next edge. Then select -> valid=1, code=5.
- btn_up and btn_select debounced on the same cycle at (0,0) -> row=1, col=0; addr_sw unchanged and no command issued.
- Reset asserted low for 1 cycle while ctrl_valid=1, addr_sw=16'hA5A5, cursor (1,6) -> all outputs 0 immediately, without waiting for a clock. A button press held during the reset registers only after a full debounce following reset release.
